// File: rtl/core_pkg.sv
// Shared pipeline-control types and constants.
// Used by the hazard controller and its consumers.
package core_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MULDIV   = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  // sll r0,r0,0 : what bubble/flush consumers load
  localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> interlock controller signal bundle.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);

  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_valid;
  logic             ex_is_load;
  logic [4:0]       ex_wb_addr;
  logic             ex_muldiv_start;
  logic             ma_mem_req;
  logic             ma_mem_ready;
  logic             branch_taken;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_bubble;
  logic             ex_ma_en;
  logic             ex_ma_bubble;
  logic             ma_wb_bubble;
  logic             muldiv_done;
  logic [1:0]       busy_state;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt,
    output id_use_rs, id_use_rt,
    output ex_valid, ex_is_load,
    output ex_wb_addr, ex_muldiv_start,
    output ma_mem_req, ma_mem_ready,
    output branch_taken,
    input  pc_en, if_id_en, if_id_flush,
    input  id_ex_en, id_ex_bubble,
    input  ex_ma_en, ex_ma_bubble,
    input  ma_wb_bubble, muldiv_done,
    input  busy_state, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt,
    input  id_use_rs, id_use_rt,
    input  ex_valid, ex_is_load,
    input  ex_wb_addr, ex_muldiv_start,
    input  ma_mem_req, ma_mem_ready,
    input  branch_taken,
    output pc_en, if_id_en, if_id_flush,
    output id_ex_en, id_ex_bubble,
    output ex_ma_en, ex_ma_bubble,
    output ma_wb_bubble, muldiv_done,
    output busy_state, stall_cycles
  );

endinterface

// File: rtl/muldiv_timer.sv
// Loadable down-counter with zero flag.
// Times multi-cycle EX occupancy (mul/div).
module muldiv_timer
  import core_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use,
// mul/div occupancy and data-memory wait.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam int TW = (MULDIV_LAT > 2)
                    ? $clog2(MULDIV_LAT) : 1;
  localparam logic [TW-1:0] LD_VAL =
    TW'(MULDIV_LAT - 2);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic mem_stall, load_use;
  logic rs_hit, rt_hit;
  logic tm_load, tm_dec, tm_zero;

  logic pc_en, if_id_en, id_ex_en, ex_ma_en;
  logic id_ex_bub, ex_ma_bub, ma_wb_bub;
  logic done;

  assign mem_stall = bus.ma_mem_req
                   & ~bus.ma_mem_ready;

  assign rs_hit = bus.id_use_rs
                & (bus.id_rs == bus.ex_wb_addr);
  assign rt_hit = bus.id_use_rt
                & (bus.id_rt == bus.ex_wb_addr);

  assign load_use = bus.ex_valid
                  & bus.ex_is_load
                  & (bus.ex_wb_addr != REG_ZERO)
                  & bus.id_valid
                  & (rs_hit | rt_hit);

  muldiv_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tm_load),
    .load_val_i(LD_VAL),
    .dec_i     (tm_dec),
    .zero_o    (tm_zero)
  );

  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    id_ex_en  = 1'b1;
    ex_ma_en  = 1'b1;
    id_ex_bub = 1'b0;
    ex_ma_bub = 1'b0;
    ma_wb_bub = 1'b0;
    done      = 1'b0;
    tm_load   = 1'b0;
    tm_dec    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_ma_en  = 1'b0;
          ma_wb_bub = 1'b1;
          state_d   = MEM_WAIT;
        end else if (bus.ex_muldiv_start) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_ma_en  = 1'b0;
          ex_ma_bub = 1'b1;
          tm_load   = 1'b1;
          state_d   = MULDIV;
        end else if (load_use) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_bub = 1'b1;
        end
      end
      MULDIV: begin
        if (!tm_zero) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_ma_en  = 1'b0;
          ex_ma_bub = 1'b1;
          tm_dec    = 1'b1;
        end else begin
          done      = 1'b1;
          state_d   = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_ma_en  = 1'b0;
          ma_wb_bub = 1'b1;
        end else begin
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      state_d   = RUN;
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_ma_en  = 1'b1;
      id_ex_bub = 1'b0;
      ex_ma_bub = 1'b0;
      ma_wb_bub = 1'b0;
      done      = 1'b0;
      tm_load   = 1'b0;
      tm_dec    = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!pc_en && stall_q != '1)
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = bus.branch_taken
                          & if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.id_ex_bubble = id_ex_bub;
  assign bus.ex_ma_en     = ex_ma_en;
  assign bus.ex_ma_bubble = ex_ma_bub;
  assign bus.ma_wb_bubble = ma_wb_bub;
  assign bus.muldiv_done  = done;
  assign bus.busy_state   = state_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl.
// MULDIV_LAT=4, CNT_W=4.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  hazard_ctrl_if #(.CNT_W(4)) bus ();

  hazard_ctrl #(
    .MULDIV_LAT(4),
    .CNT_W     (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid        = 1'b0;
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.id_use_rs       = 1'b0;
    bus.id_use_rt       = 1'b0;
    bus.ex_valid        = 1'b0;
    bus.ex_is_load      = 1'b0;
    bus.ex_wb_addr      = 5'd0;
    bus.ex_muldiv_start = 1'b0;
    bus.ma_mem_req      = 1'b0;
    bus.ma_mem_ready    = 1'b0;
    bus.branch_taken    = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    bus.ex_valid   = 1'b1;
    bus.ex_is_load = 1'b1;
    bus.ex_wb_addr = r;
    bus.id_valid   = 1'b1;
    bus.id_rs      = r;
    bus.id_use_rs  = 1'b1;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();
    @(negedge clk);
    check("rst_pc_en", 32'(bus.pc_en), 1);
    check("rst_ex_ma_en", 32'(bus.ex_ma_en), 1);
    check("rst_done", 32'(bus.muldiv_done), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(bus.busy_state), 0);
    check("rst_stall", 32'(bus.stall_cycles), 0);
    check("run_pc_en", 32'(bus.pc_en), 1);

    // load-use on r8
    tick();
    set_lu(5'd8);
    @(negedge clk);
    check("lu_pc_en", 32'(bus.pc_en), 0);
    check("lu_ifid_en", 32'(bus.if_id_en), 0);
    check("lu_bub", 32'(bus.id_ex_bubble), 1);
    check("lu_exma_en", 32'(bus.ex_ma_en), 1);
    tick();
    bus.ex_valid   = 1'b0;
    bus.ex_is_load = 1'b0;
    @(negedge clk);
    check("lu_after_pc", 32'(bus.pc_en), 1);
    check("lu_after_bub", 32'(bus.id_ex_bubble), 0);
    check("lu_stall", 32'(bus.stall_cycles), 1);
    tick();
    set_lu(5'd0);
    @(negedge clk);
    check("lu_r0_pc", 32'(bus.pc_en), 1);
    check("lu_r0_bub", 32'(bus.id_ex_bubble), 0);

    // mul/div, 4 cycles in EX
    tick();
    idle();
    bus.ex_valid        = 1'b1;
    bus.ex_muldiv_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("md_pc_en", 32'(bus.pc_en), 0);
      check("md_bub", 32'(bus.ex_ma_bubble), 1);
      check("md_done0", 32'(bus.muldiv_done), 0);
      if (i == 1)
        check("md_state", 32'(bus.busy_state), 1);
      tick();
    end
    @(negedge clk);
    check("md_done", 32'(bus.muldiv_done), 1);
    check("md_done_pc", 32'(bus.pc_en), 1);
    check("md_done_bub", 32'(bus.ex_ma_bubble), 0);
    tick();
    idle();
    @(negedge clk);
    check("md_stall", 32'(bus.stall_cycles), 4);
    check("md_idle_done", 32'(bus.muldiv_done), 0);

    // data memory wait, 5 cycles
    tick();
    bus.ma_mem_req   = 1'b1;
    bus.ma_mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mw_pc_en", 32'(bus.pc_en), 0);
      check("mw_exma_en", 32'(bus.ex_ma_en), 0);
      check("mw_bub", 32'(bus.ma_wb_bubble), 1);
      if (i == 2)
        check("mw_state", 32'(bus.busy_state), 2);
      tick();
    end
    bus.ma_mem_ready = 1'b1;
    @(negedge clk);
    check("mw_rdy_pc", 32'(bus.pc_en), 1);
    check("mw_rdy_bub", 32'(bus.ma_wb_bubble), 0);
    tick();
    idle();
    @(negedge clk);
    check("mw_stall", 32'(bus.stall_cycles), 9);
    check("mw_state_run", 32'(bus.busy_state), 0);

    // mem stall beats load-use
    tick();
    set_lu(5'd5);
    bus.ma_mem_req = 1'b1;
    @(negedge clk);
    check("pr_mw_bub", 32'(bus.ma_wb_bubble), 1);
    check("pr_lu_bub", 32'(bus.id_ex_bubble), 0);
    check("pr_ex_en", 32'(bus.id_ex_en), 0);
    tick();
    bus.ma_mem_ready = 1'b1;
    @(negedge clk);
    check("pr_rdy_pc", 32'(bus.pc_en), 1);
    tick();
    bus.ma_mem_req   = 1'b0;
    bus.ma_mem_ready = 1'b0;
    @(negedge clk);
    check("pr_lu_pc", 32'(bus.pc_en), 0);
    check("pr_lu_bub2", 32'(bus.id_ex_bubble), 1);
    tick();
    idle();
    @(negedge clk);
    check("pr_stall", 32'(bus.stall_cycles), 11);

    // branch held through a load-use stall
    tick();
    set_lu(5'd3);
    bus.branch_taken = 1'b1;
    @(negedge clk);
    check("br_flush0", 32'(bus.if_id_flush), 0);
    tick();
    bus.ex_valid   = 1'b0;
    bus.ex_is_load = 1'b0;
    @(negedge clk);
    check("br_flush1", 32'(bus.if_id_flush), 1);
    tick();
    idle();
    @(negedge clk);
    check("br_flush_off", 32'(bus.if_id_flush), 0);
    check("br_stall", 32'(bus.stall_cycles), 12);

    // reset during the 2nd MULDIV cycle
    tick();
    bus.ex_valid        = 1'b1;
    bus.ex_muldiv_start = 1'b1;
    tick();
    bus.ex_muldiv_start = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rm_done_rst", 32'(bus.muldiv_done), 0);
    check("rm_pc_rst", 32'(bus.pc_en), 1);
    tick();
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("rm_state", 32'(bus.busy_state), 0);
    check("rm_stall", 32'(bus.stall_cycles), 0);
    check("rm_pc", 32'(bus.pc_en), 1);
    check("rm_ifid", 32'(bus.if_id_en), 1);
    check("rm_idex", 32'(bus.id_ex_en), 1);
    check("rm_exma", 32'(bus.ex_ma_en), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("rm_no_done", 32'(bus.muldiv_done), 0);
    end

    // counter saturation at 4 bits
    tick();
    bus.ma_mem_req = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    @(negedge clk);
    check("sat_stall", 32'(bus.stall_cycles), 15);
    bus.ma_mem_ready = 1'b1;
    tick();
    idle();
    @(negedge clk);
    check("sat_hold", 32'(bus.stall_cycles), 15);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
